iq_upconverter: RTL
===================

// Module: iq_upconverter
// PURPOSE
//  Transmit-side counterpart of the receive mixer. Takes complex baseband IQ samples on an AXI-Stream-style input.
//  Interpolates each sample by zero-order hold (INTERP_RATIO output beats per input sample).
//  Mixes up with an internal NCO and emits the real passband sample y = I*cos(ph) - Q*sin(ph), rounded to DATA_WIDTH.
//  Sits between the TX baseband chain and the DAC interface.
// PARAMETERS
//  IQ_NUM       2   channel count of tdata_i; index 0 = I, index 1 = Q (only 2 supported)
//  DATA_WIDTH   16  signed width of input I/Q, LUT samples and output
//  PHASE_WIDTH  14  NCO phase accumulator width (unsigned, modulo 2^PHASE_WIDTH)
//  LUT_AW       10  cos/sin LUT address width; address = phase[PHASE_WIDTH-1 -: LUT_AW] (truncation)
//  INTERP_RATIO 4   output beats per accepted input sample, >= 1
// PORTS
//  clk_i          in   1                 clock
//  rst_i          in   1                 reset, asynchronous, active-high
//  en_i           in   1                 block enable; low = full stall (as tready_i low), tready_o low
//  round_type_i   in   1                 1 - round half to odd, 0 - round half to even
//  phase_inc_i    in   PHASE_WIDTH       NCO increment per output beat
//  phase_offset_i in   PHASE_WIDTH       added to accumulator before LUT lookup
//  tvalid_i       in   1                 input sample valid
//  tready_o       out  1                 input sample accepted when tvalid_i & tready_o
//  tdata_i        in   IQ_NUM*DATA_WIDTH packed [IQ_NUM-1:0][DATA_WIDTH-1:0], signed
//  tvalid_o       out  1                 output beat valid
//  tready_i       in   1                 downstream ready
//  tdata_o        out  DATA_WIDTH        signed real passband sample
// BEHAVIOUR
//  - Reset: tvalid_o=0, tdata_o=0, tready_o=0 during reset, hold regs/counter/phase acc = 0, all pipe valids = 0.
//  - Stall: pipe_en = en_i & (~tvalid_o | tready_i); every stage, hold counter and phase acc advance only on pipe_en.
//  - Hold FSM: IDLE (no sample) / HOLD (sample held, cnt 0..INTERP_RATIO-1).
//    IDLE: tready_o = en_i; on accept -> HOLD, cnt=0.
//    HOLD: one beat per pipe_en, cnt++; tready_o = en_i & (cnt==INTERP_RATIO-1) & pipe_en.
//    At last beat: accept -> reload, cnt=0 (gapless); no accept -> IDLE.
//    INTERP_RATIO=1: tready_o = en_i & pipe_en in HOLD.
//  - tready_o is combinational from tready_i; no input skid buffer.
//  - NCO: beat phase ph = acc + phase_offset_i (mod 2^PW); acc += phase_inc_i on each HOLD beat issued.
//    acc frozen in IDLE and during stall. Offset/inc changes take effect on the next issued beat.
//  - LUT: entry k = round((2^(DW-1)-1)*cos/sin(2*pi*k/2^LUT_AW)), built by constant function at elaboration.
//  - Pipeline: S1 LUT read -> S2 products (2*DW) -> S3 sum I*c - Q*s (2*DW+1) -> S4 round (output register).
//    Latency 4 cycles from beat issue to tvalid_o with no stall. Underflow drains to tvalid_o=0 between bursts.
//  - Rounding: drop DW-1 LSBs of the sum; ties resolved per round_type_i; truncate to DW per CONFIGURATION.
//  - tdata_o held stable while tvalid_o & ~tready_i.
//  - Reset mid-burst: held sample and in-flight beats discarded; restart at phase 0.
// CONFIGURATION
//  UPCONV_SAT_EN defined: rounded result saturated to [-2^(DW-1), 2^(DW-1)-1].
//  UPCONV_SAT_EN undefined: rounded result wraps (two's-complement truncation of the MSBs); no saturation logic.
// TESTING (DW=16, PW=14, LUT_AW=10, INTERP=4)
//  1 Assert rst_i mid-stream -> tvalid_o=0, tdata_o=0 immediately; after release, tready_o=1 and first output phase = offset.
//  2 inc=0, off=0, I=16384, Q=0 -> every tdata_o = 16384 (round_type_i=0) or 16383 (round_type_i=1); latency 4.
//  3 inc=0, off=2048 (45 deg), I=32767, Q=-32767 -> SAT_EN: 32767; no SAT_EN: wrapped value 46339-65536 = -19197.
//  4 Samples 100,200,300,400 (Q=0) back to back, tready_i=1, inc=0 -> tready_o high 1 in 4 cycles; 16 gapless beats, each value x4.
//  5 tready_i low 3 cycles mid-burst -> tdata_o frozen, no beat lost or duplicated, phase sequence continues unbroken.
//  6 tvalid_i drops after 2 samples, inc=256 -> tvalid_o low after 8 beats; on resume, next beat phase = 8*256 (acc frozen).

Source files
------------

// File: rtl/iq_upconverter.sv
// ---------------------------------------------------------------------------
// iq_upconverter
//
// Transmit-side IQ upconverter. Accepts complex baseband samples on an
// AXI-Stream-style input and holds each one for INTERP_RATIO output beats
// (zero-order-hold interpolation). Each beat is mixed with an internal NCO
// and emitted as the real passband sample y = I*cos(ph) - Q*sin(ph), rounded
// back to DATA_WIDTH. The block sits between the TX baseband chain and the
// DAC interface.
//
// Build option:
//   UPCONV_SAT_EN  defined   -> rounded result saturates to the signed range
//                  undefined -> rounded result wraps (MSBs dropped)
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   en_i            block enable; low stalls everything and drops tready_o
//   round_type_i    1 = round half to odd, 0 = round half to even
//   phase_inc_i     NCO increment applied per issued beat
//   phase_offset_i  phase offset added before the LUT lookup
//   tvalid_i        input sample valid
//   tready_o        input sample accepted when tvalid_i & tready_o
//   tdata_i         packed {Q, I}, signed, index 0 = I, index 1 = Q
//   tvalid_o        output beat valid
//   tready_i        downstream ready
//   tdata_o         signed real passband sample
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module iq_upconverter #(
    parameter int IQ_NUM       = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int PHASE_WIDTH  = 14,
    parameter int LUT_AW       = 10,
    parameter int INTERP_RATIO = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic                                 round_type_i,
    input  logic [PHASE_WIDTH-1:0]               phase_inc_i,
    input  logic [PHASE_WIDTH-1:0]               phase_offset_i,
    input  logic                                 tvalid_i,
    output logic                                 tready_o,
    input  logic [IQ_NUM-1:0][DATA_WIDTH-1:0]    tdata_i,
    output logic                                 tvalid_o,
    input  logic                                 tready_i,
    output logic signed [DATA_WIDTH-1:0]         tdata_o
);

    localparam int  LUT_N = 2 ** LUT_AW;
    localparam int  CNT_W = (INTERP_RATIO > 1) ? $clog2(INTERP_RATIO) : 1;
    localparam int  PROD_W = 2 * DATA_WIDTH;
    localparam int  SUM_W = 2 * DATA_WIDTH + 1;
    localparam int  RND_W = SUM_W - (DATA_WIDTH - 1);
    localparam real PI = 3.14159265358979323846;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(INTERP_RATIO - 1);
    localparam logic [DATA_WIDTH-2:0] HALF_LSB  = {1'b1, {(DATA_WIDTH-2){1'b0}}};

    // Full cosine table built at elaboration. Only the first quarter wave is
    // evaluated; the rest follows from cos symmetry. Real-to-integer rounding
    // is half away from zero, which is symmetric, so mirrored entries match
    // what a direct evaluation would give.
    function automatic logic [LUT_N*DATA_WIDTH-1:0] build_cos_lut();
        logic [LUT_N*DATA_WIDTH-1:0] lut;
        logic signed [DATA_WIDTH-1:0] v;
        real amp;
        real x;
        lut = '0;
        amp = real'((1 << (DATA_WIDTH - 1)) - 1);
        for (int k = 0; k <= LUT_N / 4; k++) begin
            x = amp * $cos(2.0 * PI * real'(k) / real'(LUT_N));
            v = DATA_WIDTH'($rtoi(x + 0.5));
            lut[k*DATA_WIDTH +: DATA_WIDTH]                         = v;
            lut[((LUT_N - k) % LUT_N)*DATA_WIDTH +: DATA_WIDTH]     = v;
            lut[(LUT_N/2 - k)*DATA_WIDTH +: DATA_WIDTH]             = -v;
            lut[(LUT_N/2 + k)*DATA_WIDTH +: DATA_WIDTH]             = -v;
        end
        return lut;
    endfunction

    localparam logic [LUT_N*DATA_WIDTH-1:0] COS_LUT = build_cos_lut();

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                         state;
    state_t                         next_state;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               next_cnt;
    logic                           load;
    logic                           issue;
    logic                           ready_c;
    logic                           pipe_en;
    logic signed [DATA_WIDTH-1:0]   hold_i;
    logic signed [DATA_WIDTH-1:0]   hold_q;
    logic [PHASE_WIDTH-1:0]         acc;
    logic [PHASE_WIDTH-1:0]         beat_phase;
    logic [LUT_AW-1:0]              cos_addr;
    logic [LUT_AW-1:0]              sin_addr;

    logic                           s1_valid;
    logic signed [DATA_WIDTH-1:0]   s1_i;
    logic signed [DATA_WIDTH-1:0]   s1_q;
    logic signed [DATA_WIDTH-1:0]   s1_cos;
    logic signed [DATA_WIDTH-1:0]   s1_sin;
    logic                           s2_valid;
    logic signed [PROD_W-1:0]       s2_ic;
    logic signed [PROD_W-1:0]       s2_qs;
    logic                           s3_valid;
    logic signed [SUM_W-1:0]        s3_sum;

    logic signed [RND_W-1:0]        floor_q;
    logic signed [RND_W-1:0]        rounded;
    logic [DATA_WIDTH-2:0]          frac;
    logic                           round_up;
    logic signed [DATA_WIDTH-1:0]   result;

    // The whole chain moves together; the output register only frees up
    // when it is empty or being consumed this cycle.
    assign pipe_en = en_i & (~tvalid_o | tready_i);

    // No skid buffer, so ready is combinational; forced low while in reset.
    assign tready_o = ready_c & ~rst_i;

    // Beat phase and LUT addresses. The sine value is the cosine table read a
    // quarter turn earlier, so a single table serves both products.
    assign beat_phase = acc + phase_offset_i;
    assign cos_addr   = LUT_AW'(beat_phase >> (PHASE_WIDTH - LUT_AW));
    assign sin_addr   = cos_addr - LUT_AW'(LUT_N / 4);

    // Hold FSM: one beat issued per enabled cycle while a sample is held; the
    // next sample is taken on the last beat so bursts stay gapless.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready_c    = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                ready_c = en_i;
                if (en_i && tvalid_i) begin
                    load       = 1'b1;
                    next_state = HOLD;
                    next_cnt   = '0;
                end
            end
            HOLD: begin
                if (pipe_en) begin
                    issue = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        ready_c  = 1'b1;
                        next_cnt = '0;
                        if (tvalid_i) begin
                            load = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            hold_i <= '0;
            hold_q <= '0;
            acc    <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (load) begin
                hold_i <= tdata_i[0];
                hold_q <= tdata_i[1];
            end
            if (issue) begin
                acc <= acc + phase_inc_i;
            end
        end
    end

    // Rounding: the sum carries DATA_WIDTH-1 fractional bits relative to the
    // output. Exact halves go up only when that makes the result even (or
    // odd, for round_type_i = 1).
    always_comb begin
        floor_q  = s3_sum[SUM_W-1 -: RND_W];
        frac     = s3_sum[DATA_WIDTH-2:0];
        round_up = 1'b0;
        if (frac > HALF_LSB) begin
            round_up = 1'b1;
        end else if (frac == HALF_LSB) begin
            round_up = round_type_i ? ~floor_q[0] : floor_q[0];
        end
        rounded = floor_q + $signed({{(RND_W-1){1'b0}}, round_up});
    end

`ifdef UPCONV_SAT_EN
    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(-(1 << (DATA_WIDTH - 1)));

    always_comb begin
        if (rounded > SAT_HI) begin
            result = DATA_WIDTH'(SAT_HI);
        end else if (rounded < SAT_LO) begin
            result = DATA_WIDTH'(SAT_LO);
        end else begin
            result = DATA_WIDTH'(rounded);
        end
    end
`else
    // Wrapping output: the MSBs above DATA_WIDTH are deliberately discarded.
    logic unused_wrap_bits;
    assign unused_wrap_bits = ^rounded[RND_W-1:DATA_WIDTH];
    assign result = rounded[DATA_WIDTH-1:0];
`endif

    // Four-stage datapath: LUT read, products, difference, round/output.
    // Every register holds while pipe_en is low, which also keeps tdata_o
    // stable while downstream is not ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_cos   <= '0;
            s1_sin   <= '0;
            s2_valid <= 1'b0;
            s2_ic    <= '0;
            s2_qs    <= '0;
            s3_valid <= 1'b0;
            s3_sum   <= '0;
            tvalid_o <= 1'b0;
            tdata_o  <= '0;
        end else if (pipe_en) begin
            s1_valid <= issue;
            s1_i     <= hold_i;
            s1_q     <= hold_q;
            s1_cos   <= COS_LUT[int'(cos_addr)*DATA_WIDTH +: DATA_WIDTH];
            s1_sin   <= COS_LUT[int'(sin_addr)*DATA_WIDTH +: DATA_WIDTH];
            s2_valid <= s1_valid;
            s2_ic    <= s1_i * s1_cos;
            s2_qs    <= s1_q * s1_sin;
            s3_valid <= s2_valid;
            s3_sum   <= $signed({s2_ic[PROD_W-1], s2_ic}) - $signed({s2_qs[PROD_W-1], s2_qs});
            tvalid_o <= s3_valid;
            if (s3_valid) begin
                tdata_o <= result;
            end
        end
    end

endmodule

`default_nettype wire
